// File: rtl/bcd_counter_display.sv
// Prescaled up/down BCD counter with programmable wrap limit, guarded load,
// and registered seven-segment outputs with leading-zero blanking.
module bcd_counter_display #(
   parameter int unsigned DIGITS         = 2,
   parameter int unsigned TICK_DIV       = 50000000,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up,
   input  logic                  clr,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic [4*DIGITS-1:0]   limit,
   output logic                  tick,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  wrap,
   output logic                  load_err,
   output logic [8*DIGITS-1:0]   seg
);

   localparam int unsigned W  = 4 * DIGITS;
   localparam int unsigned SW = 8 * DIGITS;
   localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

   logic [PW-1:0] presc, presc_nxt;
   logic [W-1:0]  bcd_nxt;
   logic          wrap_nxt, load_err_nxt;

   function automatic logic [6:0] digit_code(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h3F;
         4'd1:    return 7'h06;
         4'd2:    return 7'h5B;
         4'd3:    return 7'h4F;
         4'd4:    return 7'h66;
         4'd5:    return 7'h6D;
         4'd6:    return 7'h7D;
         4'd7:    return 7'h07;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   // Digits above the most significant nonzero digit are blanked; digit 0 always shows.
   function automatic logic [SW-1:0] seg_image(input logic [W-1:0] v);
      logic [SW-1:0] r;
      logic [7:0]    s;
      logic          seen;
      r    = '0;
      seen = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         seen = seen | (v[4*i +: 4] != 4'd0);
         s    = (seen || i == 0) ? {1'b0, digit_code(v[4*i +: 4])} : 8'h00;
         r[8*i +: 8] = SEG_ACTIVE_LOW ? ~s : s;
      end
      return r;
   endfunction

   function automatic logic all_digits_valid(input logic [W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < DIGITS; i++)
         if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      return ok;
   endfunction

   function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (c) begin
            if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
            else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         b;
      r = v;
      b = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (b) begin
            if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
            else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               b = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Valid packed BCD orders the same as plain binary, so magnitude compares are direct.
   always_comb begin
      tick         = en && (presc == PRE_MAX);
      presc_nxt    = presc;
      bcd_nxt      = bcd;
      wrap_nxt     = 1'b0;
      load_err_nxt = 1'b0;
      if (en)
         presc_nxt = tick ? '0 : presc + PW'(1);
      if (clr) begin
         bcd_nxt   = '0;
         presc_nxt = '0;
      end else if (load) begin
         if (all_digits_valid(load_val) && (load_val <= limit))
            bcd_nxt = load_val;
         else
            load_err_nxt = 1'b1;
      end else if (tick) begin
         if (up) begin
            if (bcd >= limit) begin
               bcd_nxt  = '0;
               wrap_nxt = 1'b1;
            end else begin
               bcd_nxt = bcd_inc(bcd);
            end
         end else begin
            if (bcd == '0) begin
               bcd_nxt  = limit;
               wrap_nxt = 1'b1;
            end else if (bcd > limit) begin
               bcd_nxt = limit;
            end else begin
               bcd_nxt = bcd_dec(bcd);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc    <= '0;
         bcd      <= '0;
         wrap     <= 1'b0;
         load_err <= 1'b0;
         seg      <= seg_image(W'(0));
      end else begin
         presc    <= presc_nxt;
         bcd      <= bcd_nxt;
         wrap     <= wrap_nxt;
         load_err <= load_err_nxt;
         seg      <= seg_image(bcd);
      end
   end

endmodule

// File: tb/tb_bcd_counter_display.sv
// Self-checking bench: directed scenarios plus random traffic against a
// decimal-arithmetic reference model of the counter and display.
module tb_bcd_counter_display;

   localparam int TD = 4;

   logic        clk = 1'b0;
   logic        rst, en, up, clr, load;
   logic [7:0]  load_val, limit;
   logic        tick, wrap, load_err;
   logic [7:0]  bcd;
   logic [15:0] seg;

   int errors = 0;
   int checks = 0;

   int m_val, m_pre;
   bit last_tick;

   bcd_counter_display #(.DIGITS(2), .TICK_DIV(TD), .SEG_ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
      .load_val(load_val), .limit(limit), .tick(tick), .bcd(bcd),
      .wrap(wrap), .load_err(load_err), .seg(seg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic int from_bcd(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   // Active-low display image of a decimal value 0..99.
   function automatic logic [15:0] seg_model(input int v);
      logic [7:0] codes [10];
      logic [7:0] hi, lo;
      codes = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
      lo = ~codes[v % 10];
      hi = (v / 10 == 0) ? 8'hFF : ~codes[v / 10];
      return {hi, lo};
   endfunction

   task automatic model_reset();
      m_val = 0;
      m_pre = 0;
      last_tick = 1'b0;
   endtask

   // One clock: check tick before the edge, advance the model, check registered outputs after it.
   task automatic cycle();
      int nv, np, lim;
      bit w, le, tk;
      logic [15:0] seg_exp;
      #1;
      tk = en && (m_pre == TD - 1);
      chk("tick", 32'(tick), 32'(tk));
      lim = from_bcd(limit);
      nv = m_val; w = 0; le = 0;
      np = en ? (tk ? 0 : m_pre + 1) : m_pre;
      if (clr) begin
         nv = 0; np = 0;
      end else if (load) begin
         if (load_val[7:4] <= 9 && load_val[3:0] <= 9 && from_bcd(load_val) <= lim)
            nv = from_bcd(load_val);
         else
            le = 1;
      end else if (tk) begin
         if (up) begin
            if (m_val >= lim) begin nv = 0; w = 1; end
            else nv = m_val + 1;
         end else begin
            if (m_val == 0) begin nv = lim; w = 1; end
            else if (m_val > lim) nv = lim;
            else nv = m_val - 1;
         end
      end
      seg_exp = seg_model(m_val);
      @(posedge clk);
      #1;
      m_val = nv; m_pre = np; last_tick = tk;
      chk("bcd", 32'(bcd), 32'(to_bcd(m_val)));
      chk("wrap", 32'(wrap), 32'(w));
      chk("load_err", 32'(load_err), 32'(le));
      chk("seg", 32'(seg), 32'(seg_exp));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic run_until_tick(input int budget);
      int k = 0;
      do begin
         cycle();
         k++;
      end while (!last_tick && k < budget);
      chk("tick_within_budget", 32'(last_tick), 32'd1);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_bcd"}, 32'(bcd), 32'h00);
      chk({tag, "_tick"}, 32'(tick), 32'd0);
      chk({tag, "_wrap"}, 32'(wrap), 32'd0);
      chk({tag, "_load_err"}, 32'(load_err), 32'd0);
      chk({tag, "_seg"}, 32'(seg), 32'hFFC0);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0;
      load_val = 8'h00; limit = 8'h59;
      model_reset();
      #2;
      check_reset_values("por");

      // Release and count up: first tick on the 4th edge, 10 ticks reach 10.
      @(posedge clk); #1;
      rst = 1'b0; en = 1'b1; up = 1'b1;
      run(3);
      chk("no_early_tick", 32'(bcd), 32'h00);
      run(37);
      chk("ten_ticks", 32'(bcd), 32'h10);
      en = 1'b0;
      cycle();
      chk("seg_10", 32'(seg), 32'hF9C0);

      // Display of 07 one cycle after load.
      load = 1'b1; load_val = 8'h07; cycle();
      load = 1'b0; cycle();
      chk("seg_07", 32'(seg), 32'hFFF8);

      // Up wrap from limit, then down wrap from zero.
      load = 1'b1; load_val = 8'h59; cycle();
      load = 1'b0; en = 1'b1; up = 1'b1;
      run_until_tick(8);
      chk("up_wrap_bcd", 32'(bcd), 32'h00);
      chk("up_wrap_pulse", 32'(wrap), 32'd1);
      cycle();
      chk("up_wrap_one_cycle", 32'(wrap), 32'd0);
      up = 1'b0;
      run_until_tick(8);
      chk("down_wrap_bcd", 32'(bcd), 32'h59);
      chk("down_wrap_pulse", 32'(wrap), 32'd1);

      // Loads: invalid digit rejected, valid accepted, clr wins, load beats tick.
      en = 1'b0;
      load = 1'b1; load_val = 8'h3A; cycle();
      chk("bad_load_err", 32'(load_err), 32'd1);
      chk("bad_load_hold", 32'(bcd), 32'h59);
      load_val = 8'h42; cycle();
      chk("good_load", 32'(bcd), 32'h42);
      load_val = 8'h60; cycle();
      chk("over_limit_err", 32'(load_err), 32'd1);
      clr = 1'b1; load_val = 8'h33; cycle();
      chk("clr_over_load", 32'(bcd), 32'h00);
      clr = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
      while (m_pre != TD - 1) cycle();
      load = 1'b1; load_val = 8'h25; cycle();
      chk("load_on_tick", 32'(bcd), 32'h25);
      load = 1'b0;

      // Pause mid-count and resume.
      run(6);
      en = 1'b0; run(9);
      en = 1'b1; run(9);

      // Down step above a lowered limit clamps without wrap.
      load = 1'b1; load_val = 8'h50; cycle();
      load = 1'b0; limit = 8'h20; up = 1'b0;
      run_until_tick(8);
      chk("clamp_to_limit", 32'(bcd), 32'h20);
      chk("clamp_no_wrap", 32'(wrap), 32'd0);
      limit = 8'h59;

      // Asynchronous reset between edges.
      run(5);
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      check_reset_values("async");
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         en   = ($urandom_range(0, 9) != 0);
         up   = 1'($urandom_range(0, 1));
         clr  = ($urandom_range(0, 39) == 0);
         load = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 3) == 0)
            load_val = 8'($urandom_range(0, 255));
         else
            load_val = to_bcd($urandom_range(0, 99));
         if ($urandom_range(0, 49) == 0)
            limit = to_bcd($urandom_range(0, 99));
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
